mem_port_arbiter: RTL and testbench

- Arbitrates the single data port of the integrated instruction/data memory between two requesters: r0 (CPU load/store stage) and r1 (loader/debug DMA).
- Sequences each access: drives mem_read as a level and mem_write as a clean one-cycle rising pulse, since the memory commits writes on the posedge of mem_write.
- Checks address legality before any access and returns a one-cycle ack per transaction.
- The instruction port is not touched.

---
 rtl/mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Two-requester arbiter for the data port of the shared
//             instruction/data memory. Round-robin grant on ties, address
//             legality check at grant, level-driven mem_read held for
//             READ_WAIT cycles, and a clean one-cycle mem_write pulse framed
//             by setup and hold cycles. One-cycle ack (with err) per
//             transaction. Every output is registered.
//  Ports    : clk, rst                      - clock, async active-high reset
//             rN_req/we/addr/wdata (N=0,1)  - requester access request
//             rN_ack/err/rdata              - completion pulse, error, data
//             mem_addr/wdata/read/write     - to memory data port
//             mem_rdata                     - from memory data port
//             busy                          - transaction in progress
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] DATA_LIMIT = 'h0000_1000,
    parameter int                READ_WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               gnt_q, gnt_d;        // granted requester
    logic               last_q, last_d;      // last granted requester
    logic               we_q, we_d;
    logic               ill_q, ill_d;        // latched request is illegal
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               r0_ack_q, r0_ack_d, r1_ack_q, r1_ack_d;
    logic               r0_err_q, r0_err_d, r1_err_q, r1_err_d;
    logic [DATA_W-1:0]  r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               busy_q, busy_d;

    logic               w_sel;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;             // r0 wins the first tie
            we_q        <= 1'b0;
            ill_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            r0_ack_q    <= 1'b0;
            r1_ack_q    <= 1'b0;
            r0_err_q    <= 1'b0;
            r1_err_q    <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            we_q        <= we_d;
            ill_q       <= ill_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            r0_ack_q    <= r0_ack_d;
            r1_ack_q    <= r1_ack_d;
            r0_err_q    <= r0_err_d;
            r1_err_q    <= r1_err_d;
            r0_rdata_q  <= r0_rdata_d;
            r1_rdata_q  <= r1_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        we_d        = we_q;
        ill_d       = ill_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        r0_ack_d    = 1'b0;
        r1_ack_d    = 1'b0;
        r0_err_d    = 1'b0;
        r1_err_d    = 1'b0;
        r0_rdata_d  = r0_rdata_q;
        r1_rdata_d  = r1_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        busy_d      = 1'b0;
        w_sel       = 1'b0;
        w_addr      = '0;
        w_rdata     = '0;

        // Next-state logic
        case (state_q)
            S_IDLE: begin
                if (r0_req || r1_req) begin
                    w_sel   = (r0_req && r1_req) ? ~last_q : r1_req;
                    w_addr  = w_sel ? r1_addr : r0_addr;
                    gnt_d   = w_sel;
                    last_d  = w_sel;
                    we_d    = w_sel ? r1_we : r0_we;
                    addr_d  = w_addr;
                    wdata_d = w_sel ? r1_wdata : r0_wdata;
                    ill_d   = (w_addr[1:0] != 2'b00) || (w_addr >= DATA_LIMIT);
                    cnt_d   = '0;
                    if (ill_d)
                        state_d = S_DONE;
                    else if (we_d)
                        state_d = S_WR_SETUP;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                if (cnt_q == CNT_W'(READ_WAIT - 1))
                    state_d = S_DONE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            S_WR_SETUP: state_d = S_WR_PULSE;
            S_WR_PULSE: state_d = S_WR_HOLD;
            S_WR_HOLD:  state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Outputs are a function of the state being entered, so that each
        // registered output lines up with its state.
        case (state_d)
            S_RD: begin
                mem_addr_d = addr_d;
                mem_read_d = 1'b1;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                mem_addr_d  = addr_d;
                mem_wdata_d = wdata_d;
            end
            S_WR_PULSE: begin
                mem_addr_d  = addr_d;
                mem_wdata_d = wdata_d;
                mem_write_d = 1'b1;
            end
            S_DONE: begin
                if (!ill_d && we_d)
                    mem_wdata_d = wdata_d;
                // Only a legal read returns data; writes and errors return 0.
                w_rdata = (!ill_d && !we_d) ? mem_rdata : '0;
                if (gnt_d) begin
                    r1_ack_d   = 1'b1;
                    r1_err_d   = ill_d;
                    r1_rdata_d = w_rdata;
                end else begin
                    r0_ack_d   = 1'b1;
                    r0_err_d   = ill_d;
                    r0_rdata_d = w_rdata;
                end
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign r0_ack    = r0_ack_q;
    assign r0_err    = r0_err_q;
    assign r0_rdata  = r0_rdata_q;
    assign r1_ack    = r1_ack_q;
    assign r1_err    = r1_err_q;
    assign r1_rdata  = r1_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter with a
//             byte-addressed behavioural memory on the data port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_ack, r0_err, r1_ack, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy;

    int n_vec = 0;
    int n_bad = 0;
    int wr_edges = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .DATA_LIMIT (32'h0000_1000),
        .READ_WAIT  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_ack    (r0_ack),
        .r0_err    (r0_err),
        .r0_rdata  (r0_rdata),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_ack    (r1_ack),
        .r1_err    (r1_err),
        .r1_rdata  (r1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Behavioural memory: little-endian bytes, write committed on mem_write rise.
    logic [7:0]  mem_b [0:4095];
    logic [11:0] w_ma;
    assign w_ma      = {mem_addr[11:2], 2'b00};
    assign mem_rdata = {mem_b[w_ma + 12'd3], mem_b[w_ma + 12'd2],
                        mem_b[w_ma + 12'd1], mem_b[w_ma]};

    always @(posedge mem_write) begin
        mem_b[w_ma]         = mem_wdata[7:0];
        mem_b[w_ma + 12'd1] = mem_wdata[15:8];
        mem_b[w_ma + 12'd2] = mem_wdata[23:16];
        mem_b[w_ma + 12'd3] = mem_wdata[31:24];
        wr_edges++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    // One complete transaction from requester r with protocol-correct req handling.
    task automatic run(input bit r, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input int exp_lat, input bit exp_err,
                       input logic [31:0] exp_rd, input int exp_rdc,
                       input int exp_wrc, input string tag);
        int   n, rdc, wrc;
        bit   got, oack;
        logic err;
        logic [31:0] rd;
        n = 0; rdc = 0; wrc = 0; got = 0; oack = 0; err = 1'b0; rd = '0;
        if (r) begin r1_req = 1; r1_we = we; r1_addr = a; r1_wdata = wd; end
        else   begin r0_req = 1; r0_we = we; r0_addr = a; r0_wdata = wd; end
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_read)  rdc++;
            if (mem_write) wrc++;
            oack = oack | (r ? r0_ack : r1_ack);
            if (r ? r1_ack : r0_ack) begin
                got = 1;
                err = r ? r1_err : r0_err;
                rd  = r ? r1_rdata : r0_rdata;
            end
        end
        chkb({tag, " ack_seen"}, got, 1'b1);
        chk({tag, " latency"}, n, exp_lat);
        chkb({tag, " err"}, err, exp_err);
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " mem_read_cycles"}, rdc, exp_rdc);
        chk({tag, " mem_write_cycles"}, wrc, exp_wrc);
        chkb({tag, " other_ack"}, oack, 1'b0);
        if (r) r1_req = 0; else r0_req = 0;
        @(negedge clk);
        chkb({tag, " ack_width"}, r ? r1_ack : r0_ack, 1'b0);
        chkb({tag, " busy_after"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e0, k, n, acks, wide, since;
        bit prev, stray;
        int order [0:3];

        rst = 1; r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        repeat (3) @(negedge clk);
        chkb("rst busy", busy, 1'b0);
        chkb("rst r0_ack", r0_ack, 1'b0);
        chkb("rst r1_ack", r1_ack, 1'b0);
        chkb("rst r0_err", r0_err, 1'b0);
        chkb("rst mem_read", mem_read, 1'b0);
        chkb("rst mem_write", mem_write, 1'b0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst r0_rdata", r0_rdata, 32'h0);
        chk("rst r1_rdata", r1_rdata, 32'h0);
        rst = 0;
        @(negedge clk);

        // Write then read back through r0.
        e0 = wr_edges;
        run(0, 1, 32'h10, 32'hDEAD_BEEF, 4, 0, 32'h0, 0, 1, "r0_wr10");
        chk("r0_wr10 write_edges", wr_edges - e0, 1);
        chk("byte 0x10", {24'h0, mem_b[12'h010]}, 32'hEF);
        chk("byte 0x11", {24'h0, mem_b[12'h011]}, 32'hBE);
        chk("byte 0x12", {24'h0, mem_b[12'h012]}, 32'hAD);
        chk("byte 0x13", {24'h0, mem_b[12'h013]}, 32'hDE);
        chk("idle mem_wdata", mem_wdata, 32'h0);
        chk("idle mem_addr held", mem_addr, 32'h10);
        run(0, 0, 32'h10, 32'h0, 3, 0, 32'hDEAD_BEEF, 2, 0, "r0_rd10");

        // r1 writes, including the highest legal word.
        run(1, 1, 32'h14, 32'h1234_5678, 4, 0, 32'h0, 0, 1, "r1_wr14");
        run(1, 1, 32'hFFC, 32'hA5A5_0FFC, 4, 0, 32'h0, 0, 1, "r1_wr_ffc");
        run(1, 0, 32'hFFC, 32'h0, 3, 0, 32'hA5A5_0FFC, 2, 0, "r1_rd_ffc");

        // Simultaneous requests from reset; each requester re-raises one
        // cycle after its ack so every grant decision is a tie.
        rst = 1; @(negedge clk); rst = 0; @(negedge clk);
        r0_we = 0; r0_addr = 32'h10; r1_we = 0; r1_addr = 32'h14;
        r0_req = 1; r1_req = 1;
        k = 0; n = 0;
        while (k < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (r0_ack) begin
                order[k] = 0; k++;
                chk("tie r0 rdata", r0_rdata, 32'hDEAD_BEEF);
                chkb("tie r1_ack with r0_ack", r1_ack, 1'b0);
                r0_req = 0;
            end else if (r1_ack) begin
                order[k] = 1; k++;
                chk("tie r1 rdata", r1_rdata, 32'h1234_5678);
                r1_req = 0;
            end else begin
                r0_req = 1; r1_req = 1;
            end
        end
        r0_req = 0; r1_req = 0;
        chk("tie grants", k, 4);
        chk("tie order 0", order[0], 0);
        chk("tie order 1", order[1], 1);
        chk("tie order 2", order[2], 0);
        chk("tie order 3", order[3], 1);
        repeat (2) @(negedge clk);
        chkb("tie busy after", busy, 1'b0);

        // Illegal accesses: out of range read, misaligned write.
        e0 = wr_edges;
        run(1, 0, 32'h1000, 32'h0, 1, 1, 32'h0, 0, 0, "r1_rd_1000");
        chk("illegal mem_addr held", mem_addr, 32'h14);
        run(1, 1, 32'h6, 32'h55, 1, 1, 32'h0, 0, 0, "r1_wr_6");
        chk("illegal write_edges", wr_edges - e0, 0);

        // Reset landing in WR_PULSE.
        r0_we = 1; r0_addr = 32'h20; r0_wdata = 32'hCAFE_F00D; r0_req = 1;
        @(negedge clk);
        chkb("wr20 setup mem_write", mem_write, 1'b0);
        chk("wr20 setup mem_wdata", mem_wdata, 32'hCAFE_F00D);
        @(negedge clk);
        chkb("wr20 pulse mem_write", mem_write, 1'b1);
        chkb("wr20 pulse busy", busy, 1'b1);
        #1 rst = 1;
        #1;
        chkb("midrst mem_write", mem_write, 1'b0);
        chkb("midrst busy", busy, 1'b0);
        chkb("midrst r0_ack", r0_ack, 1'b0);
        chk("midrst mem_addr", mem_addr, 32'h0);
        chk("midrst mem_wdata", mem_wdata, 32'h0);
        r0_req = 0;
        @(negedge clk);
        rst = 0;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            stray = stray | r0_ack | r1_ack | busy;
        end
        chkb("midrst no ack", stray, 1'b0);
        run(1, 0, 32'h10, 32'h0, 3, 0, 32'hDEAD_BEEF, 2, 0, "r1_rd_after_rst");

        // r0 holds req one extra cycle past its ack: two transactions.
        r0_we = 0; r0_addr = 32'h14; r0_req = 1;
        acks = 0; wide = 0; prev = 0; since = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (r0_ack) begin
                acks++;
                chk("hold rdata", r0_rdata, 32'h1234_5678);
            end
            if (r0_ack && prev) wide++;
            prev = r0_ack;
            if (since >= 0) since++;
            if (r0_ack && acks == 1) since = 0;
            if (since == 2) r0_req = 0;
        end
        r0_req = 0;
        chk("hold ack count", acks, 2);
        chk("hold wide acks", wide, 0);
        chkb("hold busy after", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
